// File: rtl/pixel_frame_pkg.sv
// Shared geometry, state encoding and address helpers for the pixel frame store.
package pixel_frame_pkg;

    localparam int unsigned XMAX    = 160;
    localparam int unsigned YMAX    = 120;
    localparam int unsigned ADDR_W  = 15;
    localparam int unsigned COLOR_W = 8;
    localparam int unsigned NPIX    = XMAX * YMAX;

    localparam logic [7:0]        XMAX_C  = 8'(XMAX);
    localparam logic [7:0]        YMAX_C  = 8'(YMAX);
    localparam logic [7:0]        XLAST_C = 8'(XMAX - 1);
    localparam logic [7:0]        YLAST_C = 8'(YMAX - 1);
    localparam logic [ADDR_W-1:0] ALAST_C = ADDR_W'(NPIX - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    // Row-major address; with XMAX=160 the constant multiply reduces to (y<<7)+(y<<5)+x.
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [7:0] x, input logic [7:0] y);
        return ADDR_W'(y) * ADDR_W'(XMAX) + ADDR_W'(x);
    endfunction

    function automatic logic in_range(input logic [7:0] x, input logic [7:0] y);
        return (x < XMAX_C) && (y < YMAX_C);
    endfunction

endpackage

// File: rtl/pixel_frame_store_frame_ram.sv
// Frame memory: port A write + registered write-first read, port B registered read-only.
module frame_ram
    import pixel_frame_pkg::*;
(
    input  logic               clk,
    input  logic               we_a_i,
    input  logic [ADDR_W-1:0]  addr_a_i,
    input  logic [COLOR_W-1:0] wdata_a_i,
    output logic [COLOR_W-1:0] rdata_a_o,
    input  logic [ADDR_W-1:0]  addr_b_i,
    output logic [COLOR_W-1:0] rdata_b_o
);

    logic [COLOR_W-1:0] mem [0:NPIX-1];
    logic [COLOR_W-1:0] rdata_a_q;
    logic [COLOR_W-1:0] rdata_b_q;

    always_ff @(posedge clk) begin
        if (we_a_i) begin
            mem[addr_a_i] <= wdata_a_i;
            rdata_a_q     <= wdata_a_i;
        end else begin
            rdata_a_q     <= mem[addr_a_i];
        end
        // Port B samples the pre-write contents when both ports hit the same pixel.
        rdata_b_q <= mem[addr_b_i];
    end

    assign rdata_a_o = rdata_a_q;
    assign rdata_b_o = rdata_b_q;

endmodule

// File: rtl/pixel_frame_store.sv
// Pixel frame store: clear-on-reset, processor plot/lookup, raster scan-out.
// Optional plot counter enabled by PIXEL_FRAME_STORE_PLOT_COUNT_EN.
//
// state | meaning
// CLEAR | writing CLEAR_COLOR to every pixel, processor traffic ignored
// RUN   | processor plots/lookups accepted, raster scan-out running
module pixel_frame_store
    import pixel_frame_pkg::*;
#(
    parameter logic [COLOR_W-1:0] CLEAR_COLOR = 8'h00,
    parameter logic [COLOR_W-1:0] OOB_COLOR   = 8'hFF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         x,
    input  logic [7:0]         y,
    input  logic [COLOR_W-1:0] color_draw,
    input  logic               plot,
    output logic [COLOR_W-1:0] color_obs,
    output logic               ready,
    output logic [7:0]         scan_x,
    output logic [7:0]         scan_y,
    output logic [COLOR_W-1:0] scan_color,
    output logic               scan_valid,
    output logic [15:0]        plot_count
);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  clr_addr_q, clr_addr_d;
    logic               ready_q, ready_d;
    logic               obs_run_q, obs_run_d;
    logic               obs_oob_q, obs_oob_d;
    logic [7:0]         rast_x_q, rast_x_d;
    logic [7:0]         rast_y_q, rast_y_d;
    logic [7:0]         scan_x_q, scan_x_d;
    logic [7:0]         scan_y_q, scan_y_d;
    logic               scan_valid_q, scan_valid_d;

    logic               we_a;
    logic [ADDR_W-1:0]  addr_a;
    logic [COLOR_W-1:0] wdata_a;
    logic [COLOR_W-1:0] rdata_a;
    logic [ADDR_W-1:0]  addr_b;
    logic [COLOR_W-1:0] rdata_b;

    logic               proc_in_range;
    logic               plot_accept;

    assign proc_in_range = in_range(x, y);
    assign plot_accept   = (state_q == RUN) && plot && proc_in_range;

    always_comb begin
        state_d      = state_q;
        clr_addr_d   = clr_addr_q;
        ready_d      = ready_q;
        obs_run_d    = 1'b0;
        obs_oob_d    = 1'b0;
        rast_x_d     = rast_x_q;
        rast_y_d     = rast_y_q;
        scan_x_d     = scan_x_q;
        scan_y_d     = scan_y_q;
        scan_valid_d = 1'b0;
        we_a         = 1'b0;
        addr_a       = clr_addr_q;
        wdata_a      = CLEAR_COLOR;
        addr_b       = pix_addr(rast_x_q, rast_y_q);

        case (state_q)
            CLEAR: begin
                we_a = 1'b1;
                if (clr_addr_q == ALAST_C) begin
                    state_d = RUN;
                    ready_d = 1'b1;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
            RUN: begin
                // Out-of-range coordinates alias onto legal addresses, so park port A at 0.
                addr_a       = proc_in_range ? pix_addr(x, y) : '0;
                wdata_a      = color_draw;
                we_a         = plot_accept;
                obs_run_d    = 1'b1;
                obs_oob_d    = !proc_in_range;
                scan_valid_d = 1'b1;
                scan_x_d     = rast_x_q;
                scan_y_d     = rast_y_q;
                if (rast_x_q == XLAST_C) begin
                    rast_x_d = '0;
                    rast_y_d = (rast_y_q == YLAST_C) ? '0 : rast_y_q + 1'b1;
                end else begin
                    rast_x_d = rast_x_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= CLEAR;
            clr_addr_q   <= '0;
            ready_q      <= 1'b0;
            obs_run_q    <= 1'b0;
            obs_oob_q    <= 1'b0;
            rast_x_q     <= '0;
            rast_y_q     <= '0;
            scan_x_q     <= '0;
            scan_y_q     <= '0;
            scan_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_addr_q   <= clr_addr_d;
            ready_q      <= ready_d;
            obs_run_q    <= obs_run_d;
            obs_oob_q    <= obs_oob_d;
            rast_x_q     <= rast_x_d;
            rast_y_q     <= rast_y_d;
            scan_x_q     <= scan_x_d;
            scan_y_q     <= scan_y_d;
            scan_valid_q <= scan_valid_d;
        end
    end

    frame_ram u_frame_ram (
        .clk       (clk),
        .we_a_i    (we_a),
        .addr_a_i  (addr_a),
        .wdata_a_i (wdata_a),
        .rdata_a_o (rdata_a),
        .addr_b_i  (addr_b),
        .rdata_b_o (rdata_b)
    );

    // RAM read registers carry no reset; the flag registers gate them to the reset values.
    assign color_obs  = obs_oob_q ? OOB_COLOR : (obs_run_q ? rdata_a : '0);
    assign ready      = ready_q;
    assign scan_x     = scan_x_q;
    assign scan_y     = scan_y_q;
    assign scan_color = scan_valid_q ? rdata_b : '0;
    assign scan_valid = scan_valid_q;

`ifdef PIXEL_FRAME_STORE_PLOT_COUNT_EN
    logic [15:0] plot_cnt_q, plot_cnt_d;

    always_comb begin
        plot_cnt_d = plot_cnt_q;
        if (plot_accept && (plot_cnt_q != 16'hFFFF)) begin
            plot_cnt_d = plot_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            plot_cnt_q <= '0;
        end else begin
            plot_cnt_q <= plot_cnt_d;
        end
    end

    assign plot_count = plot_cnt_q;
`else
    assign plot_count = '0;
`endif

endmodule

// File: tb/tb_pixel_frame_store.sv
// Directed, table-driven bench for pixel_frame_store (clear, plot/lookup, scan-out, reset).
module tb_pixel_frame_store;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] x, y, color_draw;
    logic       plot;
    logic [7:0] color_obs;
    logic       ready;
    logic [7:0] scan_x, scan_y, scan_color;
    logic       scan_valid;
    logic [15:0] plot_count;

    int checks = 0;
    int errors = 0;

`ifdef PIXEL_FRAME_STORE_PLOT_COUNT_EN
    localparam int CNT_EN = 1;
`else
    localparam int CNT_EN = 0;
`endif

    pixel_frame_store dut (
        .clk        (clk),
        .reset      (reset),
        .x          (x),
        .y          (y),
        .color_draw (color_draw),
        .plot       (plot),
        .color_obs  (color_obs),
        .ready      (ready),
        .scan_x     (scan_x),
        .scan_y     (scan_y),
        .scan_color (scan_color),
        .scan_valid (scan_valid),
        .plot_count (plot_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       pl;
        logic [7:0] vx;
        logic [7:0] vy;
        logic [7:0] vc;
        logic [7:0] exp_obs;
        int         acc;
    } vec_t;

    localparam int NV = 19;
    vec_t vt [NV];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (ready !== 1'b1 && n < 20000) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n;
        int exp_cnt;
        bit found;

        vt[0]  = '{1'b0, 8'd0,   8'd0,   8'h00, 8'h00, 0};
        vt[1]  = '{1'b0, 8'd159, 8'd119, 8'h00, 8'h00, 0};
        vt[2]  = '{1'b0, 8'd80,  8'd60,  8'h00, 8'h00, 0};
        vt[3]  = '{1'b0, 8'd3,   8'd3,   8'h00, 8'h00, 0};
        vt[4]  = '{1'b1, 8'd10,  8'd20,  8'h3C, 8'h3C, 1};
        vt[5]  = '{1'b0, 8'd10,  8'd20,  8'h00, 8'h3C, 0};
        vt[6]  = '{1'b0, 8'd11,  8'd20,  8'h00, 8'h00, 0};
        vt[7]  = '{1'b1, 8'd5,   8'd5,   8'hA5, 8'hA5, 1};
        vt[8]  = '{1'b0, 8'd5,   8'd5,   8'h00, 8'hA5, 0};
        vt[9]  = '{1'b1, 8'd160, 8'd0,   8'h77, 8'hFF, 0};
        vt[10] = '{1'b0, 8'd160, 8'd0,   8'h00, 8'hFF, 0};
        vt[11] = '{1'b0, 8'd0,   8'd1,   8'h00, 8'h00, 0};
        vt[12] = '{1'b1, 8'd0,   8'd120, 8'h55, 8'hFF, 0};
        vt[13] = '{1'b0, 8'd0,   8'd120, 8'h00, 8'hFF, 0};
        vt[14] = '{1'b0, 8'd255, 8'd255, 8'h00, 8'hFF, 0};
        vt[15] = '{1'b1, 8'd159, 8'd119, 8'h11, 8'h11, 1};
        vt[16] = '{1'b1, 8'd0,   8'd0,   8'h42, 8'h42, 1};
        vt[17] = '{1'b0, 8'd0,   8'd0,   8'h00, 8'h42, 0};
        vt[18] = '{1'b0, 8'd159, 8'd119, 8'h00, 8'h11, 0};

        reset = 1'b1; x = 8'd0; y = 8'd0; color_draw = 8'd0; plot = 1'b0;
        exp_cnt = 0;
        step();
        step();
        chk("rst_ready",      32'(ready),      32'd0);
        chk("rst_color_obs",  32'(color_obs),  32'd0);
        chk("rst_scan_valid", 32'(scan_valid), 32'd0);
        chk("rst_scan_x",     32'(scan_x),     32'd0);
        chk("rst_scan_y",     32'(scan_y),     32'd0);
        chk("rst_scan_color", 32'(scan_color), 32'd0);
        chk("rst_plot_count", 32'(plot_count), 32'd0);

        // Plots during the clear must be ignored.
        reset = 1'b0;
        plot = 1'b1; x = 8'd3; y = 8'd3; color_draw = 8'h99;
        for (int i = 0; i < 50; i++) step();
        chk("clear_color_obs", 32'(color_obs), 32'd0);
        chk("clear_ready",     32'(ready),     32'd0);
        for (int i = 0; i < 50; i++) step();
        plot = 1'b0; color_draw = 8'h00;
        wait_ready(n);
        chk("clear_len", 32'(n + 100), 32'd19200);
        chk("clear_plot_count", 32'(plot_count), 32'd0);
        chk("scan_valid_first", 32'(scan_valid), 32'd0);
        step();
        chk("scan_valid_up", 32'(scan_valid), 32'd1);
        chk("scan_first_x",  32'(scan_x),     32'd0);
        chk("scan_first_y",  32'(scan_y),     32'd0);
        chk("scan_first_c",  32'(scan_color), 32'd0);

        for (int i = 0; i < NV; i++) begin
            plot = vt[i].pl; x = vt[i].vx; y = vt[i].vy; color_draw = vt[i].vc;
            step();
            exp_cnt += vt[i].acc * CNT_EN;
            chk($sformatf("obs[%0d]", i),  32'(color_obs),  32'(vt[i].exp_obs));
            chk($sformatf("cnt[%0d]", i),  32'(plot_count), 32'(exp_cnt));
        end
        plot = 1'b0; color_draw = 8'h00;

        // Frame corner and wrap to origin.
        found = 1'b0;
        for (int i = 0; i < 20000 && !found; i++) begin
            step();
            if (scan_valid && scan_x == 8'd159 && scan_y == 8'd119) begin
                chk("scan_last_c", 32'(scan_color), 32'h11);
                step();
                chk("wrap_valid", 32'(scan_valid), 32'd1);
                chk("wrap_x",     32'(scan_x),     32'd0);
                chk("wrap_y",     32'(scan_y),     32'd0);
                chk("wrap_c",     32'(scan_color), 32'h42);
                found = 1'b1;
            end
        end
        chk("wrap_found", 32'(found), 32'd1);

        // Pixel plotted in the same cycle the scan reads it: scan sees the old value.
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            step();
            if (scan_valid && scan_x == 8'd49 && scan_y == 8'd7) begin
                plot = 1'b1; x = 8'd50; y = 8'd7; color_draw = 8'hC3;
                step();
                plot = 1'b0; color_draw = 8'h00;
                exp_cnt += CNT_EN;
                chk("race_scan_x", 32'(scan_x),     32'd50);
                chk("race_scan_y", 32'(scan_y),     32'd7);
                chk("race_scan_c", 32'(scan_color), 32'h00);
                chk("race_obs_wf", 32'(color_obs),  32'hC3);
                step();
                chk("race_obs",    32'(color_obs),  32'hC3);
                chk("race_cnt",    32'(plot_count), 32'(exp_cnt));
                found = 1'b1;
            end
        end
        chk("race_found", 32'(found), 32'd1);

        // Asynchronous reset from RUN, then reset again mid-clear.
        #2 reset = 1'b1;
        #1;
        chk("arst_ready",      32'(ready),      32'd0);
        chk("arst_scan_valid", 32'(scan_valid), 32'd0);
        chk("arst_color_obs",  32'(color_obs),  32'd0);
        chk("arst_plot_count", 32'(plot_count), 32'd0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 5000; i++) step();
        chk("mid_ready", 32'(ready), 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(ready), 32'd0);
        step();
        reset = 1'b0;
        wait_ready(n);
        chk("reclear_len",   32'(n),          32'd19200);
        chk("reclear_count", 32'(plot_count), 32'd0);
        x = 8'd10; y = 8'd20;
        step();
        chk("reclear_obs_10_20", 32'(color_obs), 32'h00);
        x = 8'd50; y = 8'd7;
        step();
        chk("reclear_obs_50_7", 32'(color_obs), 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
